sqrt_rr_sequencer: RTL and testbench

//   Shares one iterative integer square-root engine between NREQ requesters.

---
 rtl/sqrt_rr_sequencer.sv | 112 +++++++++++
 tb/tb_sqrt_rr_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_rr_sequencer.sv
// Round-robin shared iterative square-root engine.
// One root bit per cycle, MSB first; tagged result on a valid/ready port.
module sqrt_rr_sequencer #(
  parameter  int NREQ  = 2,
  parameter  int IN_W  = 23,
  localparam int OUT_W = (IN_W + 1) / 2,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_radicand,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_W-1:0]     res_root,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy
);

  localparam int BW = $clog2(OUT_W);
  localparam int SW = 2 * OUT_W;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_last;
  logic [IN_W-1:0]  rad;
  logic [ID_W-1:0]  id;
  logic [OUT_W-1:0] root;
  logic [BW-1:0]    bitn;

  logic [ID_W-1:0]  gnt;
  logic [ID_W-1:0]  idx;
  logic             found;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ID_W'((int'(rr_last) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign req_ready = (state == IDLE && found)
                   ? (NREQ'(1) << gnt) : '0;
  assign busy = (state != IDLE);

  logic [OUT_W-1:0] t;
  logic [SW-1:0]    sq;
  logic [OUT_W-1:0] next_root;

  assign t  = root | (OUT_W'(1) << bitn);
  assign sq = {{OUT_W{1'b0}}, t} * {{OUT_W{1'b0}}, t};
  assign next_root = (sq <= SW'(rad)) ? t : root;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= ID_W'(NREQ - 1);
      rad       <= '0;
      id        <= '0;
      root      <= '0;
      bitn      <= '0;
      res_valid <= 1'b0;
      res_root  <= '0;
      res_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            rad     <= req_radicand[int'(gnt)*IN_W +: IN_W];
            id      <= gnt;
            rr_last <= gnt;
            root    <= '0;
            bitn    <= BW'(OUT_W - 1);
            state   <= CALC;
          end
        end
        CALC: begin
          root <= next_root;
          if (bitn == '0) begin
            res_root  <= next_root;
            res_id    <= id;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            bitn <= bitn - BW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_rr_sequencer.sv
// Bench for sqrt_rr_sequencer: cycle model with arithmetic floor-sqrt,
// per-cycle compare, plus directed literal checks.
module tb_sqrt_rr_sequencer;

  localparam int NREQ  = 2;
  localparam int IN_W  = 23;
  localparam int OUT_W = 12;
  localparam int ID_W  = 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_radicand;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [OUT_W-1:0]     res_root;
  logic [ID_W-1:0]      res_id;
  logic                 busy;

  sqrt_rr_sequencer #(.NREQ(NREQ), .IN_W(IN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_radicand (req_radicand),
    .req_ready    (req_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_root     (res_root),
    .res_id       (res_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int isqrt(input longint x);
    int r;
    r = $rtoi($sqrt(real'(x)));
    while (longint'(r) * r > x) r--;
    while (longint'(r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Reference: mode 0 idle, 1 computing, 2 holding result.
  int m_mode = 0, m_left = 0, m_last = NREQ - 1;
  int m_proot = 0, m_pid = 0;
  int m_rv = 0, m_root = 0, m_id = 0;
  int m_acc = 0, m_abandon = 0, hs = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    int g;
    if (reset) begin
      if (m_mode != 0) m_abandon++;
      m_mode = 0; m_last = NREQ - 1;
      m_rv = 0; m_root = 0; m_id = 0;
    end else begin
      case (m_mode)
        0: begin
          g = pick(req_valid, m_last);
          if (g >= 0) begin
            m_mode  = 1;
            m_left  = OUT_W;
            m_proot = isqrt(longint'(req_radicand[g*IN_W +: IN_W]));
            m_pid   = g;
            m_last  = g;
            m_acc++;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 2; m_rv = 1;
            m_root = m_proot; m_id = m_pid;
          end
        end
        default: if (res_ready) begin m_mode = 0; m_rv = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    int g;
    longint exp_rr;
    if (chk_en) begin
      g = pick(req_valid, m_last);
      exp_rr = (m_mode == 0 && g >= 0) ? (longint'(1) << g) : 0;
      chk("req_ready", req_ready, exp_rr);
      chk("busy", busy, m_mode != 0);
      chk("res_valid", res_valid, m_rv);
      chk("res_root", res_root, m_root);
      chk("res_id", res_id, m_id);
      if (res_valid && res_ready) hs++;
    end
  end

  task automatic req(input int id, input int rad);
    bit got = 0;
    @(posedge clk); #1;
    req_valid[id] = 1'b1;
    req_radicand[id*IN_W +: IN_W] = IN_W'(rad);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL grant_timeout: req %0d never granted", id);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (res_valid) begin lat = n; return; end
    end
    total++; bad++;
    $display("FAIL res_timeout: res_valid never rose");
  endtask

  task automatic one(input int id, input int rad, input int exp_root);
    int lat;
    req(id, rad);
    wait_res(lat);
    chk("lit_latency", lat, OUT_W + 1);
    chk("lit_root", res_root, exp_root);
    chk("lit_id", res_id, id);
  endtask

  bit rnd_en = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_en) res_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int g_id[4], g_cyc[4], r_id[4], r_cyc[4], r_rt[4];
  int ng, nr, cyc, lat;

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_radicand = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;

    // reset state
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_root", res_root, 0);
    chk("rst_id", res_id, 0);
    chk("rst_req_ready", req_ready, 0);

    // zero radicand, then boundary and floor cases from req1
    one(0, 0, 0);
    one(1, 8388607, 2896);
    one(1, 1000000, 1000);
    one(1, 24, 4);
    one(1, 25, 5);

    // fairness and throughput with both requesters held valid
    @(posedge clk); #1;
    req_radicand[0 +: IN_W] = IN_W'(144);
    req_radicand[IN_W +: IN_W] = IN_W'(99);
    req_valid = 2'b11;
    ng = 0; nr = 0; cyc = 0;
    for (int n = 0; n < 120 && nr < 4; n++) begin
      @(negedge clk);
      cyc++;
      if (req_ready != 0 && ng < 4) begin
        g_id[ng] = req_ready[1]; g_cyc[ng] = cyc; ng++;
        if (ng == 4) begin @(posedge clk); #1 req_valid = '0; end
      end
      if (res_valid && nr < 4) begin
        r_id[nr] = res_id; r_cyc[nr] = cyc; r_rt[nr] = res_root; nr++;
      end
    end
    chk("rr_grants", ng, 4);
    chk("rr_results", nr, 4);
    chk("rr_first_lat", r_cyc[0] - g_cyc[0], OUT_W + 1);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant_id", g_id[i], i % 2);
      chk("rr_res_id", r_id[i], i % 2);
      chk("rr_res_root", r_rt[i], (i % 2) ? 9 : 12);
      if (i > 0) begin
        chk("rr_grant_gap", g_cyc[i] - g_cyc[i-1], OUT_W + 2);
        chk("rr_res_gap", r_cyc[i] - r_cyc[i-1], OUT_W + 2);
      end
    end

    // result stall in DONE
    req(0, 1000);
    res_ready = 1'b0;
    req_radicand[IN_W +: IN_W] = IN_W'(50);
    req_valid[1] = 1'b1;
    wait_res(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", res_valid, 1);
      chk("stall_root", res_root, 31);
      chk("stall_id", res_id, 0);
      chk("stall_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("release_valid_pre", res_valid, 1);
    @(negedge clk);
    chk("release_valid_post", res_valid, 0);
    chk("release_busy", busy, 0);

    // reset in the sixth CALC cycle
    req(0, 5000000);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    req_radicand[0 +: IN_W] = IN_W'(49);
    req_radicand[IN_W +: IN_W] = IN_W'(64);
    req_valid = 2'b11;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_grant", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = '0;
    wait_res(lat);
    chk("abort_next_root", res_root, 7);
    chk("abort_next_id", res_id, 0);

    // random radicands with random result back-pressure
    rnd_en = 1;
    for (int i = 0; i < 2500; i++) begin
      int id, rad, r;
      id = $urandom_range(0, NREQ - 1);
      case ($urandom_range(0, 7))
        0: rad = 0;
        1: rad = (1 << IN_W) - 1;
        2: begin r = $urandom_range(0, 2896); rad = r * r; end
        3: begin r = $urandom_range(1, 2896); rad = r * r - 1; end
        default: rad = $urandom_range(0, (1 << IN_W) - 1);
      endcase
      req(id, rad);
    end
    rnd_en = 0;
    @(posedge clk); #2 res_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy && !res_valid) break;
    end
    chk("end_busy", busy, 0);
    chk("answered_once", hs, m_acc - m_abandon);
    chk("abandoned", m_abandon, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
